// File: rtl/clp_out_writer.sv
//------------------------------------------------------------------------------
// clp_out_writer: captures CLP result words, applies optional per-lane ReLU and
// writes them to one of two ping-pong feature memories. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clp_out_writer #(
    parameter int Tm            = 4,
    parameter int FEATURE_WIDTH = 8,
    parameter int ADDR_WIDTH    = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          state,
    input  logic                          feature_out_select,
    input  logic                          relu_enable,
    input  logic [15:0]                   out_count,
    input  logic                          CLP_output_flag,
    input  logic [Tm*FEATURE_WIDTH-1:0]   CLP_output,
    output logic                          feature_mem_write_enable_0,
    output logic                          feature_mem_write_enable_1,
    output logic [ADDR_WIDTH-1:0]         feature_mem_write_addr_0,
    output logic [ADDR_WIDTH-1:0]         feature_mem_write_addr_1,
    output logic [Tm*FEATURE_WIDTH-1:0]   feature_mem_write_data_0,
    output logic [Tm*FEATURE_WIDTH-1:0]   feature_mem_write_data_1,
    output logic                          layer_done,
    output logic [15:0]                   words_written,
    output logic                          err_overflow,
    output logic                          err_short,
    output logic                          err_idle_flag
);

    localparam int         c_WORD_W = Tm * FEATURE_WIDTH;
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]            r_fsm;
    logic                  r_state_d;
    logic                  r_sel;
    logic                  r_relu;
    logic [15:0]           r_count;
    logic [15:0]           r_words;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we0;
    logic                  r_we1;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [c_WORD_W-1:0]   r_wr_data;
    logic                  r_layer_done;
    logic                  r_err_overflow;
    logic                  r_err_short;
    logic                  r_err_idle;

    logic                  w_start;
    logic                  w_last;
    logic [c_WORD_W-1:0]   w_relu_word;

    assign w_start = state & ~r_state_d;
    assign w_last  = ((r_words + 16'd1) == r_count);

    for (genvar i = 0; i < Tm; i++) begin : g_lane
        logic [FEATURE_WIDTH-1:0] w_lane;
        assign w_lane = CLP_output[i*FEATURE_WIDTH +: FEATURE_WIDTH];
        assign w_relu_word[i*FEATURE_WIDTH +: FEATURE_WIDTH] =
            (r_relu && w_lane[FEATURE_WIDTH-1]) ? '0 : w_lane;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm          <= c_IDLE;
            r_state_d      <= 1'b0;
            r_sel          <= 1'b0;
            r_relu         <= 1'b0;
            r_count        <= '0;
            r_words        <= '0;
            r_addr         <= '0;
            r_we0          <= 1'b0;
            r_we1          <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_layer_done   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_short    <= 1'b0;
            r_err_idle     <= 1'b0;
        end else begin
            r_state_d    <= state;
            r_we0        <= 1'b0;
            r_we1        <= 1'b0;
            r_layer_done <= 1'b0;
            case (r_fsm)
                c_IDLE: begin
                    if (w_start) begin
                        r_sel          <= feature_out_select;
                        r_relu         <= relu_enable;
                        r_count        <= out_count;
                        r_words        <= '0;
                        r_addr         <= '0;
                        r_err_overflow <= 1'b0;
                        r_err_short    <= 1'b0;
                        r_err_idle     <= 1'b0;
                        if (out_count == 16'd0) begin
                            r_fsm        <= c_DONE;
                            r_layer_done <= 1'b1;
                        end else begin
                            r_fsm <= c_RUN;
                        end
                    end else if (CLP_output_flag) begin
                        r_err_idle <= 1'b1;
                    end
                end
                c_RUN: begin
                    if (CLP_output_flag) begin
                        r_we0     <= ~r_sel;
                        r_we1     <= r_sel;
                        r_wr_addr <= r_addr;
                        r_wr_data <= w_relu_word;
                        r_addr    <= r_addr + 1'b1;
                        r_words   <= r_words + 16'd1;
                    end
                    // Completion takes priority over a simultaneous falling state.
                    if (CLP_output_flag && w_last) begin
                        r_fsm        <= c_DONE;
                        r_layer_done <= 1'b1;
                    end else if (!state) begin
                        r_fsm       <= c_IDLE;
                        r_err_short <= 1'b1;
                    end
                end
                c_DONE: begin
                    if (CLP_output_flag) begin
                        r_err_overflow <= 1'b1;
                    end
                    r_fsm <= c_IDLE;
                end
                default: r_fsm <= c_IDLE;
            endcase
        end
    end

    assign feature_mem_write_enable_0 = r_we0;
    assign feature_mem_write_enable_1 = r_we1;
    assign feature_mem_write_addr_0   = r_wr_addr;
    assign feature_mem_write_addr_1   = r_wr_addr;
    assign feature_mem_write_data_0   = r_wr_data;
    assign feature_mem_write_data_1   = r_wr_data;
    assign layer_done                 = r_layer_done;
    assign words_written              = r_words;
    assign err_overflow               = r_err_overflow;
    assign err_short                  = r_err_short;
    assign err_idle_flag              = r_err_idle;

endmodule

`default_nettype wire
